sdram_block_dma: RTL and testbench
==================================

SDRAM_BLOCK_DMA -- requirements
Module: sdram_block_dma

Interface
REQ-001 SHALL have parameter TMO_BITS, default 8: width of the ack-timeout counter; timeout limit is 2^TMO_BITS-1 clocks.
REQ-002 SHALL have port clk, input, 1: single clock for all logic; all outputs are registered on the rising edge of clk.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request to start a block transfer; sampled only in IDLE.
REQ-005 SHALL have port dir, input, 1: transfer direction; 0 = SDRAM->buffer (read), 1 = buffer->SDRAM (write); latched on start.
REQ-006 SHALL have port base_adr, input, 21 ([21:1]): SDRAM word address of the first word; latched on start.
REQ-007 SHALL have port count, input, 8: number of words to transfer; 0 means 256; latched on start.
REQ-008 SHALL have port busy, output, 1: a transfer is in progress.
REQ-009 SHALL have port done, output, 1: one-clock pulse marking the end of a transfer.
REQ-010 SHALL have port err, output, 1: the last transfer aborted on ack timeout.
REQ-011 SHALL have port buf_adr, output, 8: word index into the local sector buffer.
REQ-012 SHALL have port buf_we, output, 1: buffer write strobe.
REQ-013 SHALL have port buf_wdata, output, 16: data to write into the buffer.
REQ-014 SHALL have port buf_rdata, input, 16: buffer read data; synchronous, valid one clock after buf_adr.
REQ-015 SHALL have port sdram_ready, input, 1: SDRAM initialisation is complete.
REQ-016 SHALL have ports sdram_stb (output, 1), sdram_we (output, 1), sdram_sel (output, 2), sdram_adr (output, 21, [21:1]), sdram_out (output, 16), sdram_dat (input, 16) and sdram_ack (input, 1): the initiator side of the SDRAM strobe/ack bus.

Function
REQ-017 SHALL implement the states IDLE, WAITRDY, LOAD, SETUP, BUS, GAP1, GAP2 and FIN.
REQ-018 In IDLE with start=1, SHALL latch dir, base_adr and count, clear err, set busy=1, set the word index to 0, and go to WAITRDY.
REQ-019 SHALL ignore start whenever busy=1.
REQ-020 In WAITRDY, SHALL stay while sdram_ready=0 (no timeout) and go to LOAD when sdram_ready=1.
REQ-021 In LOAD, SHALL drive buf_adr = word index for one clock.
REQ-022 In SETUP, SHALL drive sdram_adr = base_adr + index (modulo 2^21), sdram_we = dir and sdram_sel = 2'b11 with sdram_stb=0; for dir=1 it SHALL capture buf_rdata into sdram_out.
REQ-023 sdram_adr, sdram_we, sdram_sel and sdram_out SHALL be stable from SETUP until stb falls, because the responder latches byte masks on the rising edge of stb.
REQ-024 In BUS, SHALL hold sdram_stb=1 until sdram_ack=1 is sampled; on ack it SHALL drop stb on the next clock and go to GAP1; for dir=0 it SHALL capture sdram_dat into buf_wdata.
REQ-025 In GAP1, for dir=0, SHALL pulse buf_we=1 for exactly one clock with buf_adr = index.
REQ-026 SHALL hold stb=0 through GAP1 and GAP2 (at least 2 clocks), so the responder's ack pipeline clears before the next strobe.
REQ-027 In GAP2, SHALL increment the index; if the index reaches the latched count (256 when count=0), it goes to FIN, otherwise to LOAD.
REQ-028 Per word, the transfer SHALL take 5 + k clocks, where k is the number of clocks from the stb rise to the ack sample (k >= 1).
REQ-029 SHALL keep a timeout counter that resets on each stb rise and counts in BUS.
REQ-030 When the timeout counter reaches 2^TMO_BITS-1 without ack, SHALL drop stb, set err=1 and go to FIN; no further buffer write for that word.
REQ-031 An ack arriving outside BUS SHALL be ignored.
REQ-032 In FIN, SHALL pulse done=1 for one clock, clear busy and return to IDLE; err SHALL hold until the next accepted start.
REQ-033 A start asserted in the same clock as done SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-034 With rst_n=0, all outputs SHALL go to 0 asynchronously (including sdram_stb, sdram_sel and err), the state SHALL go to IDLE and the index to 0.
REQ-035 Reset asserted mid-transfer SHALL drop stb immediately and lose the transfer; no done pulse SHALL be produced.

Verification
REQ-036 Read: dir=0, base_adr=21'h000100, count=4, ack 2 clocks after each stb -> SDRAM words 0x100..0x103 land in buffer 0..3, 4 buf_we pulses, done after 28 clocks of transfer, err=0.
REQ-037 Write wrap: dir=1, base_adr=21'h1FFFFF, count=2, buffer = {16'h1234, 16'h5678} -> sdram_out=16'h1234 at adr 21'h1FFFFF, then 16'h5678 at adr 21'h000000, sel=2'b11, we=1.
REQ-038 Count zero: count=0, ack 1 clock after each stb -> exactly 256 stb pulses, buf_adr covers 0..255, one done pulse.
REQ-039 Timeout: TMO_BITS=4, ack never asserted -> stb high for 15 clocks, then falls; err=1, one done pulse, busy=0; the next start clears err.
REQ-040 Not ready and reset: sdram_ready=0 for 50 clocks after start -> no stb; then assert rst_n=0 while in BUS -> stb=0 in the same clock, no done pulse, a new start is accepted normally.

Source files
------------

// File: rtl/sdram_block_dma.sv
// Block DMA engine moving up to 256 words between a local sector buffer and SDRAM
// over a strobe/ack bus, one word at a time, with an ack timeout.
module sdram_block_dma #(
  parameter int unsigned TMO_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dir,
  input  logic [21:1] base_adr,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  buf_adr,
  output logic        buf_we,
  output logic [15:0] buf_wdata,
  input  logic [15:0] buf_rdata,
  input  logic        sdram_ready,
  output logic        sdram_stb,
  output logic        sdram_we,
  output logic [1:0]  sdram_sel,
  output logic [21:1] sdram_adr,
  output logic [15:0] sdram_out,
  input  logic [15:0] sdram_dat,
  input  logic        sdram_ack
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAITRDY = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] SETUP   = 3'd3;
  localparam logic [2:0] BUS     = 3'd4;
  localparam logic [2:0] GAP1    = 3'd5;
  localparam logic [2:0] GAP2    = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  // Last counter value before the limit; the abort edge is where the limit is reached.
  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'((2 ** TMO_BITS) - 2);

  logic [2:0]          state_q, state_d;
  logic                dir_q, dir_d;
  logic [21:1]         base_q, base_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          idx_q, idx_d;
  logic [TMO_BITS-1:0] tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                buf_we_q, buf_we_d;
  logic [15:0]         buf_wdata_q, buf_wdata_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [1:0]          sel_q, sel_d;
  logic [21:1]         adr_q, adr_d;
  logic [15:0]         out_q, out_d;

  logic [8:0] total;
  logic [8:0] idx_next;

  assign total    = (cnt_q == 8'd0) ? 9'd256 : {1'b0, cnt_q};
  assign idx_next = {1'b0, idx_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    buf_we_d    = 1'b0;
    buf_wdata_d = buf_wdata_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    out_d       = out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = dir;
          base_d  = base_adr;
          cnt_d   = count;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 8'd0;
          state_d = WAITRDY;
        end
      end
      WAITRDY: begin
        if (sdram_ready) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Address and controls become visible in SETUP and stay put until stb falls.
        adr_d   = base_q + {13'd0, idx_q};
        we_d    = dir_q;
        sel_d   = 2'b11;
        state_d = SETUP;
      end
      SETUP: begin
        if (dir_q) begin
          out_d = buf_rdata;
        end
        state_d = BUS;
      end
      BUS: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          tmo_d = '0;
        end else if (sdram_ack) begin
          stb_d = 1'b0;
          if (!dir_q) begin
            buf_wdata_d = sdram_dat;
            buf_we_d    = 1'b1;
          end
          state_d = GAP1;
        end else if (tmo_q == TMO_LAST) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP1: begin
        state_d = GAP2;
      end
      GAP2: begin
        idx_d = idx_q + 8'd1;
        if (idx_next == total) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          state_d = LOAD;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_wdata_q <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 2'b00;
      adr_q       <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      buf_we_q    <= buf_we_d;
      buf_wdata_q <= buf_wdata_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      out_q       <= out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign buf_adr   = idx_q;
  assign buf_we    = buf_we_q;
  assign buf_wdata = buf_wdata_q;
  assign sdram_stb = stb_q;
  assign sdram_we  = we_q;
  assign sdram_sel = sel_q;
  assign sdram_adr = adr_q;
  assign sdram_out = out_q;

endmodule

// File: tb/tb_sdram_block_dma.sv
// Scoreboard bench for sdram_block_dma: a strobe/ack SDRAM responder and a synchronous
// buffer model feed the DUT; a negedge monitor pops expected transfers from queues.
module tb_sdram_block_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [21:1] base_adr;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  buf_adr;
  logic        buf_we;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata = 16'h0000;
  logic        sdram_ready;
  logic        sdram_stb;
  logic        sdram_we;
  logic [1:0]  sdram_sel;
  logic [21:1] sdram_adr;
  logic [15:0] sdram_out;
  logic [15:0] sdram_dat;
  logic        sdram_ack = 1'b0;

  typedef struct {
    logic [7:0]  badr;
    logic [15:0] data;
  } rd_exp_t;

  typedef struct {
    logic [21:1] adr;
    logic [15:0] data;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int checks = 0;
  int failures = 0;

  logic [15:0] bmem [256];
  logic        cov [256];
  logic        mode_wr = 1'b0;
  logic        mon_en = 1'b0;
  logic        ack_en = 1'b1;
  int          ack_k = 2;
  int          hcnt = 0;

  int stb_rises, stb_high_cyc, done_cnt, busy_cyc, we_cnt;
  logic        stb_prev = 1'b0;
  logic [21:1] hold_adr;
  logic [15:0] hold_out;
  logic        hold_we;
  logic [1:0]  hold_sel;

  sdram_block_dma #(.TMO_BITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dir         (dir),
    .base_adr    (base_adr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .buf_adr     (buf_adr),
    .buf_we      (buf_we),
    .buf_wdata   (buf_wdata),
    .buf_rdata   (buf_rdata),
    .sdram_ready (sdram_ready),
    .sdram_stb   (sdram_stb),
    .sdram_we    (sdram_we),
    .sdram_sel   (sdram_sel),
    .sdram_adr   (sdram_adr),
    .sdram_out   (sdram_out),
    .sdram_dat   (sdram_dat),
    .sdram_ack   (sdram_ack)
  );

  always #5 clk = ~clk;

  // SDRAM contents are a fixed function of the word address.
  assign sdram_dat = sdram_adr[16:1] ^ 16'h5A00;

  always @(posedge clk) buf_rdata <= bmem[buf_adr];

  // Ack is raised ack_k clocks after the stb rise and falls once stb drops.
  always @(negedge clk) begin
    if (!sdram_stb) hcnt = 0;
    else hcnt = hcnt + 1;
    sdram_ack = ack_en && sdram_stb && (hcnt == ack_k);
  end

  always @(negedge clk) begin : mon
    rd_exp_t re;
    wr_exp_t wx;
    if (mon_en) begin
      if (sdram_stb) stb_high_cyc++;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (sdram_stb && !stb_prev) begin
        stb_rises++;
        hold_adr = sdram_adr;
        hold_out = sdram_out;
        hold_we  = sdram_we;
        hold_sel = sdram_sel;
        if (mode_wr) begin
          checks++;
          if (wr_q.size() == 0) begin
            failures++;
            $display("FAIL sdram_write unexpected adr=%h out=%h", sdram_adr, sdram_out);
          end else begin
            wx = wr_q.pop_front();
            if (sdram_adr !== wx.adr || sdram_out !== wx.data || sdram_we !== 1'b1 ||
                sdram_sel !== 2'b11) begin
              failures++;
              $display("FAIL sdram_write adr=%h out=%h we=%b sel=%b required adr=%h out=%h we=1 sel=11",
                       sdram_adr, sdram_out, sdram_we, sdram_sel, wx.adr, wx.data);
            end
          end
        end
      end else if (sdram_stb && stb_prev) begin
        checks++;
        if (sdram_adr !== hold_adr || sdram_out !== hold_out || sdram_we !== hold_we ||
            sdram_sel !== hold_sel) begin
          failures++;
          $display("FAIL bus_stable adr=%h out=%h required adr=%h out=%h",
                   sdram_adr, sdram_out, hold_adr, hold_out);
        end
      end
      if (buf_we) begin
        we_cnt++;
        cov[buf_adr] = 1'b1;
        checks++;
        if (mode_wr || rd_q.size() == 0) begin
          failures++;
          $display("FAIL buf_write unexpected adr=%h data=%h", buf_adr, buf_wdata);
        end else begin
          re = rd_q.pop_front();
          if (buf_adr !== re.badr || buf_wdata !== re.data) begin
            failures++;
            $display("FAIL buf_write adr=%h data=%h required adr=%h data=%h",
                     buf_adr, buf_wdata, re.badr, re.data);
          end
        end
      end
      stb_prev = sdram_stb;
    end
  end

  task automatic clear_counts();
    stb_rises = 0; stb_high_cyc = 0; done_cnt = 0; busy_cyc = 0; we_cnt = 0;
    for (int i = 0; i < 256; i++) cov[i] = 1'b0;
  endtask

  task automatic push_reads(input logic [21:1] b, input int n);
    logic [21:1] a;
    for (int i = 0; i < n; i++) begin
      a = b + 21'(i);
      rd_q.push_back('{badr: 8'(i), data: a[16:1] ^ 16'h5A00});
    end
  endtask

  task automatic pulse_start(input logic d, input logic [21:1] b, input logic [7:0] c);
    @(negedge clk);
    dir = d; base_adr = b; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_adr = '0; count = '0; sdram_ready = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, buf_adr, buf_we, buf_wdata, sdram_stb, sdram_we, sdram_sel,
         sdram_adr, sdram_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b stb=%b sel=%b err=%b required all zero",
               busy, sdram_stb, sdram_sel, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sdram_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b stb=%b required 0 0", busy, sdram_stb);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_read();
    int n;
    mode_wr = 1'b0; ack_k = 2; clear_counts();
    push_reads(21'h000100, 4);
    pulse_start(1'b0, 21'h000100, 8'd4);
    // A second start while busy must not disturb the transfer.
    @(negedge clk);
    dir = 1'b1; base_adr = 21'h0ABCDE; count = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin failures++; $display("FAIL read_done_timeout done=0 required 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() != 0 || we_cnt != 4) begin
      failures++;
      $display("FAIL read_words left=%0d we=%0d required 0 4", rd_q.size(), we_cnt);
    end
    checks++;
    if (busy_cyc != 30) begin
      failures++;
      $display("FAIL read_latency busy_cycles=%0d required 30", busy_cyc);
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0 || stb_rises != 4) begin
      failures++;
      $display("FAIL read_end done=%0d err=%b busy=%b stb=%0d required 1 0 0 4",
               done_cnt, err, busy, stb_rises);
    end
  endtask

  task automatic test_write_wrap();
    int n;
    mode_wr = 1'b1; ack_k = 2; clear_counts();
    bmem[0] = 16'h1234; bmem[1] = 16'h5678;
    wr_q.push_back('{adr: 21'h1FFFFF, data: 16'h1234});
    wr_q.push_back('{adr: 21'h000000, data: 16'h5678});
    pulse_start(1'b1, 21'h1FFFFF, 8'd2);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin failures++; $display("FAIL write_done_timeout done=0 required 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || stb_rises != 2 || we_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL write_end left=%0d stb=%0d we=%0d done=%0d required 0 2 0 1",
               wr_q.size(), stb_rises, we_cnt, done_cnt);
    end
  endtask

  task automatic test_count_zero();
    int n;
    int covered;
    mode_wr = 1'b0; ack_k = 1; clear_counts();
    push_reads(21'h012345, 256);
    pulse_start(1'b0, 21'h012345, 8'd0);
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin failures++; $display("FAIL count0_done_timeout done=0 required 1"); end
    repeat (3) @(negedge clk);
    covered = 0;
    for (int i = 0; i < 256; i++) if (cov[i]) covered++;
    checks++;
    if (stb_rises != 256 || covered != 256 || we_cnt != 256) begin
      failures++;
      $display("FAIL count0_words stb=%0d covered=%0d we=%0d required 256 256 256",
               stb_rises, covered, we_cnt);
    end
    checks++;
    if (done_cnt != 1 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL count0_end done=%0d left=%0d required 1 0", done_cnt, rd_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    mode_wr = 1'b0; ack_en = 1'b0; ack_k = 2; clear_counts();
    pulse_start(1'b0, 21'h000200, 8'd3);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin failures++; $display("FAIL tmo_done_timeout done=0 required 1"); end
    repeat (4) @(negedge clk);
    checks++;
    if (stb_high_cyc != 15 || stb_rises != 1) begin
      failures++;
      $display("FAIL tmo_stb high=%0d rises=%0d required 15 1", stb_high_cyc, stb_rises);
    end
    checks++;
    if (err !== 1'b1 || done_cnt != 1 || busy !== 1'b0 || we_cnt != 0) begin
      failures++;
      $display("FAIL tmo_end err=%b done=%0d busy=%b we=%0d required 1 1 0 0",
               err, done_cnt, busy, we_cnt);
    end
    ack_en = 1'b1; clear_counts();
    push_reads(21'h000300, 1);
    pulse_start(1'b0, 21'h000300, 8'd1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_err_clear err=%b busy=%b required 0 1", err, busy);
    end
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    // Start offered only during the done clock must be dropped.
    start = 1'b1; dir = 1'b0; base_adr = 21'h0; count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1 || rd_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL done_start busy=%b done=%0d left=%0d err=%b required 0 1 0 0",
               busy, done_cnt, rd_q.size(), err);
    end
  endtask

  task automatic test_notready_reset();
    int n;
    mode_wr = 1'b0; ack_k = 2; clear_counts();
    sdram_ready = 1'b0;
    pulse_start(1'b0, 21'h000000, 8'd4);
    repeat (50) @(negedge clk);
    checks++;
    if (stb_rises != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL notready stb=%0d busy=%b required 0 1", stb_rises, busy);
    end
    sdram_ready = 1'b1;
    n = 0;
    while (!sdram_stb && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!sdram_stb) begin failures++; $display("FAIL ready_stb_timeout stb=0 required 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sdram_stb !== 1'b0 || busy !== 1'b0 || sdram_sel !== 2'b00) begin
      failures++;
      $display("FAIL midreset stb=%b busy=%b sel=%b required 0 0 00", sdram_stb, busy, sdram_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nodone done=%0d busy=%b required 0 0", done_cnt, busy);
    end
    push_reads(21'h000040, 1);
    pulse_start(1'b0, 21'h000040, 8'd1);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1 || rd_q.size() != 0 || we_cnt != 1) begin
      failures++;
      $display("FAIL after_reset done=%0d left=%0d we=%0d required 1 0 1",
               done_cnt, rd_q.size(), we_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 16'(i * 3);
    clear_counts();
    test_reset();
    test_read();
    test_write_wrap();
    test_count_zero();
    test_timeout();
    test_notready_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
